y86_decode_stage: RTL and testbench
===================================

// Module: y86_decode_stage
// PURPOSE
//  Decode stage of the 5-stage Y86-64 pipeline, sitting between the D and E pipeline registers.
//  Holds the 15 x 64-bit program register file, written from the W stage.
//  Derives srcA/srcB/dstE/dstM from icode, rA and rB.
//  Produces forwarded valA/valB from the E, M and W stages.
// PARAMETERS
//  RSP_RESET_VAL  64'h0  value loaded into %rsp (reg 4) on reset; all other regs reset to 0
// PORTS
//  clk        in   1   clock; all state updates on posedge
//  rst        in   1   synchronous, active-high reset
//  D_stat     in   4   status from D register; passed through to d_stat
//  D_icode    in   4   instruction code
//  D_ifun     in   4   function code
//  D_rA       in   4   register specifier A
//  D_rB       in   4   register specifier B
//  D_valC     in   64  constant word
//  D_valP     in   64  incremented PC
//  e_dstE     in   4   execute-stage destination E
//  e_valE     in   64  execute-stage ALU result
//  M_dstE     in   4   M-register destination E
//  M_valE     in   64  M-register value E
//  M_dstM     in   4   M-register destination M
//  m_valM     in   64  memory-stage read data
//  W_dstE     in   4   writeback destination E
//  W_valE     in   64  writeback value E
//  W_dstM     in   4   writeback destination M
//  W_valM     in   64  writeback value M
//  d_stat     out  4   = D_stat
//  d_icode    out  4   = D_icode
//  d_ifun     out  4   = D_ifun
//  d_valC     out  64  = D_valC
//  d_valA     out  64  operand A
//  d_valB     out  64  operand B
//  d_srcA     out  4   source register A
//  d_srcB     out  4   source register B
//  d_dstE     out  4   destination register E
//  d_dstM     out  4   destination register M
// BEHAVIOUR
//  - icode map: 0 halt, 1 nop, 2 rrmovq/cmovXX, 3 irmovq, 4 rmmovq, 5 mrmovq, 6 OPq, 7 jXX,
//    8 call, 9 ret, A pushq, B popq. 4'hF = "no register"; RSP = 4.
//  - Register mapping by icode:
//    - d_srcA = rA for {2,4,6,A}; RSP for {9,B}; else F.
//    - d_srcB = rB for {4,5,6}; RSP for {8,9,A,B}; else F.
//    - d_dstE = rB for {2,3,6}; RSP for {8,9,A,B}; else F.
//      cmov gating is not done here; execute squashes dstE on !Cnd.
//    - d_dstM = rA for {5,B}; else F.
//  - d_valA priority, first match wins:
//    1. icode in {7,8} -> D_valP
//    2. srcA == e_dstE -> e_valE
//    3. srcA == M_dstM -> m_valM
//    4. srcA == M_dstE -> M_valE
//    5. srcA == W_dstM -> W_valM
//    6. srcA == W_dstE -> W_valE
//    7. otherwise regfile[srcA]
//  - d_valB: same priority chain for srcB, without the valP step.
//  - A forwarding match requires src != F. A src of F yields 0 for the operand.
//  - All d_* outputs are purely combinational; zero latency from the D register.
//  - Reads are combinational. Same-cycle write/read is covered by the W forwarding paths.
//  - Write at posedge clk when !rst:
//    - W_dstE != F: reg[W_dstE] <= W_valE.
//    - W_dstM != F: reg[W_dstM] <= W_valM.
//    - W_dstE == W_dstM (not F): W_valM wins (popq %rsp semantics).
//    - Index F is never written.
//  - rst=1 at posedge: reg0..14 <= 0, reg4 <= RSP_RESET_VAL. Writes in that cycle are dropped.
//    Reset mid-program discards any pending W write.
//  - Upstream bubbles must use dstE/dstM = F so they never forward.
// CONFIGURATION
//  DECODE_REG_SNOOP_EN
//  - Defined: adds outputs reg_file0..reg_file14 (64 b each) = current register contents,
//    for debug/monitor.
//  - Undefined: these ports are absent; functionality is otherwise identical.
// TESTING
//  - Reset with RSP_RESET_VAL=64'h100, then idle -> all regs 0 except reg4=0x100;
//    nop (icode 1) -> srcA=srcB=dstE=dstM=F.
//  - W_dstE=3, W_valE=7 for 1 cycle; then D_icode=6, rA=3, rB=3 with no hazards ->
//    d_valA=d_valB=7, d_dstE=3.
//  - D_icode=6, rA=2, with e_dstE=2/e_valE=5 and M_dstE=2/M_valE=9 and W_dstE=2/W_valE=1 ->
//    d_valA=5. Remove e match -> 9. Remove M match -> 1.
//  - D_icode=B (popq rA=0) -> srcA=srcB=4, dstE=4, dstM=0.
//    Write W_dstE=4/W_valE=8 and W_dstM=4/W_valM=0x55 together -> reg4=0x55.
//  - D_icode=8 (call), D_valP=0x20, with e_dstE=4 -> d_valA=0x20 (valP beats forwarding),
//    d_valB=e_valE.
//  - W_dstE=F, W_valE=0xDEAD -> no register changes; rst asserted with W_dstE=1 -> reg1=0.

Source files
------------

// File: rtl/y86_decode_stage_if.sv
// y86_decode_stage_if: D-register inputs, forwarding sources and decode outputs of the decode stage
interface y86_decode_stage_if;
    logic [3:0]  D_stat;
    logic [3:0]  D_icode;
    logic [3:0]  D_ifun;
    logic [3:0]  D_rA;
    logic [3:0]  D_rB;
    logic [63:0] D_valC;
    logic [63:0] D_valP;
    logic [3:0]  e_dstE;
    logic [63:0] e_valE;
    logic [3:0]  M_dstE;
    logic [63:0] M_valE;
    logic [3:0]  M_dstM;
    logic [63:0] m_valM;
    logic [3:0]  W_dstE;
    logic [63:0] W_valE;
    logic [3:0]  W_dstM;
    logic [63:0] W_valM;
    logic [3:0]  d_stat;
    logic [3:0]  d_icode;
    logic [3:0]  d_ifun;
    logic [63:0] d_valC;
    logic [63:0] d_valA;
    logic [63:0] d_valB;
    logic [3:0]  d_srcA;
    logic [3:0]  d_srcB;
    logic [3:0]  d_dstE;
    logic [3:0]  d_dstM;
    modport master (
        output D_stat, D_icode, D_ifun, D_rA, D_rB, D_valC, D_valP,
        output e_dstE, e_valE, M_dstE, M_valE, M_dstM, m_valM,
        output W_dstE, W_valE, W_dstM, W_valM,
        input  d_stat, d_icode, d_ifun, d_valC, d_valA, d_valB,
        input  d_srcA, d_srcB, d_dstE, d_dstM
    );
    modport slave (
        input  D_stat, D_icode, D_ifun, D_rA, D_rB, D_valC, D_valP,
        input  e_dstE, e_valE, M_dstE, M_valE, M_dstM, m_valM,
        input  W_dstE, W_valE, W_dstM, W_valM,
        output d_stat, d_icode, d_ifun, d_valC, d_valA, d_valB,
        output d_srcA, d_srcB, d_dstE, d_dstM
    );
endinterface

// File: rtl/y86_decode_stage.sv
// y86_decode_stage: Y86-64 decode with register file and E/M/W forwarding; DECODE_REG_SNOOP_EN adds reg_file0..14 debug outputs
module y86_decode_stage #(
    parameter logic [63:0] RSP_RESET_VAL = 64'h0
) (
    input  logic              clk,
    input  logic              rst,
    y86_decode_stage_if.slave io_dec
`ifdef DECODE_REG_SNOOP_EN
    ,
    output logic [63:0]       reg_file0,
    output logic [63:0]       reg_file1,
    output logic [63:0]       reg_file2,
    output logic [63:0]       reg_file3,
    output logic [63:0]       reg_file4,
    output logic [63:0]       reg_file5,
    output logic [63:0]       reg_file6,
    output logic [63:0]       reg_file7,
    output logic [63:0]       reg_file8,
    output logic [63:0]       reg_file9,
    output logic [63:0]       reg_file10,
    output logic [63:0]       reg_file11,
    output logic [63:0]       reg_file12,
    output logic [63:0]       reg_file13,
    output logic [63:0]       reg_file14
`endif
);
    localparam logic [3:0] RNONE = 4'hF, RSP = 4'h4;
    localparam logic [3:0] IRRMOVQ = 4'h2, IIRMOVQ = 4'h3, IRMMOVQ = 4'h4, IMRMOVQ = 4'h5,
                           IOPQ = 4'h6, IJXX = 4'h7, ICALL = 4'h8, IRET = 4'h9,
                           IPUSHQ = 4'hA, IPOPQ = 4'hB;
    // entry 15 is the "no register" slot: reset only, never written or read
    logic [63:0] r_regs [0:15];
    logic [3:0]  w_ic, w_src_a, w_src_b, w_dst_e, w_dst_m;
    logic [63:0] w_val_a, w_val_b;
    assign w_ic = io_dec.D_icode;
    // register specifiers derived from icode
    always_comb begin
        w_src_a = (w_ic == IRRMOVQ || w_ic == IRMMOVQ || w_ic == IOPQ || w_ic == IPUSHQ) ? io_dec.D_rA :
                  (w_ic == IRET || w_ic == IPOPQ) ? RSP : RNONE;
        w_src_b = (w_ic == IRMMOVQ || w_ic == IMRMOVQ || w_ic == IOPQ) ? io_dec.D_rB :
                  (w_ic == ICALL || w_ic == IRET || w_ic == IPUSHQ || w_ic == IPOPQ) ? RSP : RNONE;
        w_dst_e = (w_ic == IRRMOVQ || w_ic == IIRMOVQ || w_ic == IOPQ) ? io_dec.D_rB :
                  (w_ic == ICALL || w_ic == IRET || w_ic == IPUSHQ || w_ic == IPOPQ) ? RSP : RNONE;
        w_dst_m = (w_ic == IMRMOVQ || w_ic == IPOPQ) ? io_dec.D_rA : RNONE;
    end
    // operand selection: valP for jXX/call, then youngest forwarding source first, then register file
    always_comb begin
        w_val_a = (w_ic == IJXX || w_ic == ICALL) ? io_dec.D_valP :
                  (w_src_a == RNONE)          ? 64'h0 :
                  (w_src_a == io_dec.e_dstE)  ? io_dec.e_valE :
                  (w_src_a == io_dec.M_dstM)  ? io_dec.m_valM :
                  (w_src_a == io_dec.M_dstE)  ? io_dec.M_valE :
                  (w_src_a == io_dec.W_dstM)  ? io_dec.W_valM :
                  (w_src_a == io_dec.W_dstE)  ? io_dec.W_valE : r_regs[w_src_a];
        w_val_b = (w_src_b == RNONE)          ? 64'h0 :
                  (w_src_b == io_dec.e_dstE)  ? io_dec.e_valE :
                  (w_src_b == io_dec.M_dstM)  ? io_dec.m_valM :
                  (w_src_b == io_dec.M_dstE)  ? io_dec.M_valE :
                  (w_src_b == io_dec.W_dstM)  ? io_dec.W_valM :
                  (w_src_b == io_dec.W_dstE)  ? io_dec.W_valE : r_regs[w_src_b];
    end
    // register file write-back; dstM is assigned last so it wins a collision with dstE (popq %rsp)
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) r_regs[i] <= (i == 4) ? RSP_RESET_VAL : 64'h0;
        end else begin
            if (io_dec.W_dstE != RNONE) r_regs[io_dec.W_dstE] <= io_dec.W_valE;
            if (io_dec.W_dstM != RNONE) r_regs[io_dec.W_dstM] <= io_dec.W_valM;
        end
    end
    assign io_dec.d_stat  = io_dec.D_stat;
    assign io_dec.d_icode = io_dec.D_icode;
    assign io_dec.d_ifun  = io_dec.D_ifun;
    assign io_dec.d_valC  = io_dec.D_valC;
    assign io_dec.d_valA  = w_val_a;
    assign io_dec.d_valB  = w_val_b;
    assign io_dec.d_srcA  = w_src_a;
    assign io_dec.d_srcB  = w_src_b;
    assign io_dec.d_dstE  = w_dst_e;
    assign io_dec.d_dstM  = w_dst_m;
`ifdef DECODE_REG_SNOOP_EN
    assign reg_file0  = r_regs[0];
    assign reg_file1  = r_regs[1];
    assign reg_file2  = r_regs[2];
    assign reg_file3  = r_regs[3];
    assign reg_file4  = r_regs[4];
    assign reg_file5  = r_regs[5];
    assign reg_file6  = r_regs[6];
    assign reg_file7  = r_regs[7];
    assign reg_file8  = r_regs[8];
    assign reg_file9  = r_regs[9];
    assign reg_file10 = r_regs[10];
    assign reg_file11 = r_regs[11];
    assign reg_file12 = r_regs[12];
    assign reg_file13 = r_regs[13];
    assign reg_file14 = r_regs[14];
`endif
endmodule

// File: tb/tb_y86_decode_stage.sv
// tb_y86_decode_stage: directed checks of decode mapping, forwarding priority and register file
module tb_y86_decode_stage;
    logic clk;
    logic rst;
    int   n_checks;
    int   n_fails;
    y86_decode_stage_if dif ();
    y86_decode_stage #(.RSP_RESET_VAL(64'h100)) dut (
        .clk(clk),
        .rst(rst),
        .io_dec(dif)
    );
    initial clk = 1'b0;
    always #5 clk = ~clk;
    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end
    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask
    task automatic idle_fwd();
        dif.e_dstE = 4'hF;
        dif.M_dstE = 4'hF;
        dif.M_dstM = 4'hF;
        dif.W_dstE = 4'hF;
        dif.W_dstM = 4'hF;
    endtask
    task automatic set_d(input logic [3:0] ic, input logic [3:0] ra, input logic [3:0] rb);
        dif.D_icode = ic;
        dif.D_rA = ra;
        dif.D_rB = rb;
        #1;
    endtask
    task automatic chk_reg(input string tag, input logic [3:0] r, input logic [63:0] exp);
        set_d(4'h6, r, r);
        chk(tag, dif.d_valA, exp);
    endtask
    initial begin
        n_checks = 0;
        n_fails = 0;
        rst = 1'b1;
        dif.D_stat = 4'h1;
        dif.D_ifun = 4'h0;
        dif.D_valC = 64'h0;
        dif.D_valP = 64'h0;
        dif.e_valE = 64'h0;
        dif.M_valE = 64'h0;
        dif.m_valM = 64'h0;
        dif.W_valE = 64'h0;
        dif.W_valM = 64'h0;
        idle_fwd();
        set_d(4'h1, 4'hF, 4'hF);
        tick();
        tick();
        rst = 1'b0;
        tick();
        for (int i = 0; i < 15; i++) chk_reg($sformatf("reset_reg%0d", i), 4'(i), (i == 4) ? 64'h100 : 64'h0);
        set_d(4'h1, 4'h3, 4'h5);
        chk("nop_srcA", 64'(dif.d_srcA), 64'hF);
        chk("nop_srcB", 64'(dif.d_srcB), 64'hF);
        chk("nop_dstE", 64'(dif.d_dstE), 64'hF);
        chk("nop_dstM", 64'(dif.d_dstM), 64'hF);
        chk("nop_valA", dif.d_valA, 64'h0);
        dif.D_stat = 4'h2;
        dif.D_ifun = 4'h5;
        dif.D_valC = 64'hCAFE_0000_1234;
        #1;
        chk("pass_stat", 64'(dif.d_stat), 64'h2);
        chk("pass_ifun", 64'(dif.d_ifun), 64'h5);
        chk("pass_valC", dif.d_valC, 64'hCAFE_0000_1234);
        dif.W_dstE = 4'h3;
        dif.W_valE = 64'h7;
        set_d(4'h6, 4'h3, 4'h3);
        chk("w_fwd_same_cycle", dif.d_valA, 64'h7);
        tick();
        idle_fwd();
        set_d(4'h6, 4'h3, 4'h3);
        chk("opq_valA", dif.d_valA, 64'h7);
        chk("opq_valB", dif.d_valB, 64'h7);
        chk("opq_dstE", 64'(dif.d_dstE), 64'h3);
        chk("opq_srcA", 64'(dif.d_srcA), 64'h3);
        dif.e_dstE = 4'h2;
        dif.e_valE = 64'h5;
        dif.M_dstE = 4'h2;
        dif.M_valE = 64'h9;
        dif.W_dstE = 4'h2;
        dif.W_valE = 64'h1;
        set_d(4'h6, 4'h2, 4'hF);
        chk("fwd_e", dif.d_valA, 64'h5);
        dif.e_dstE = 4'hF;
        #1;
        chk("fwd_M_valE", dif.d_valA, 64'h9);
        dif.M_dstM = 4'h2;
        dif.m_valM = 64'h33;
        #1;
        chk("fwd_m_valM_over_M_valE", dif.d_valA, 64'h33);
        dif.M_dstM = 4'hF;
        dif.M_dstE = 4'hF;
        #1;
        chk("fwd_W_valE", dif.d_valA, 64'h1);
        dif.W_dstM = 4'h2;
        dif.W_valM = 64'h44;
        #1;
        chk("fwd_W_valM_over_W_valE", dif.d_valA, 64'h44);
        dif.W_dstM = 4'hF;
        tick();
        idle_fwd();
        chk_reg("reg2_after_W", 4'h2, 64'h1);
        set_d(4'hB, 4'h0, 4'hF);
        chk("popq_srcA", 64'(dif.d_srcA), 64'h4);
        chk("popq_srcB", 64'(dif.d_srcB), 64'h4);
        chk("popq_dstE", 64'(dif.d_dstE), 64'h4);
        chk("popq_dstM", 64'(dif.d_dstM), 64'h0);
        chk("popq_valA_rsp", dif.d_valA, 64'h100);
        dif.W_dstE = 4'h4;
        dif.W_valE = 64'h8;
        dif.W_dstM = 4'h4;
        dif.W_valM = 64'h55;
        tick();
        idle_fwd();
        chk_reg("popq_rsp_collision", 4'h4, 64'h55);
        dif.D_valP = 64'h20;
        dif.e_dstE = 4'h4;
        dif.e_valE = 64'h77;
        set_d(4'h8, 4'h0, 4'h0);
        chk("call_valA_valP", dif.d_valA, 64'h20);
        chk("call_valB_fwd_e", dif.d_valB, 64'h77);
        chk("call_srcA", 64'(dif.d_srcA), 64'hF);
        chk("call_dstE", 64'(dif.d_dstE), 64'h4);
        idle_fwd();
        set_d(4'h7, 4'h0, 4'h0);
        chk("jxx_valA_valP", dif.d_valA, 64'h20);
        chk("jxx_valB_none", dif.d_valB, 64'h0);
        dif.W_valE = 64'hDEAD;
        dif.W_valM = 64'hBEEF;
        tick();
        chk_reg("noF_write_reg3", 4'h3, 64'h7);
        chk_reg("noF_write_reg2", 4'h2, 64'h1);
        chk_reg("noF_write_reg0", 4'h0, 64'h0);
        rst = 1'b1;
        dif.W_dstE = 4'h1;
        dif.W_valE = 64'h99;
        tick();
        rst = 1'b0;
        idle_fwd();
        tick();
        chk_reg("rst_drops_write_reg1", 4'h1, 64'h0);
        chk_reg("rst_reg4", 4'h4, 64'h100);
        chk_reg("rst_reg3", 4'h3, 64'h0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
        $finish;
    end
endmodule
